dcache_2way: RTL and testbench



---
 rtl/dcache_pkg.sv | 18 +
 rtl/dcache_way.sv | 52 +++++
 rtl/dcache_2way.sv | 129 ++++++++++++
 tb/tb_dcache_2way.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared FSM state type and geometry helpers for the two-way data cache.
package dcache_pkg;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, REFILL, DONE} state_t;

  function automatic int off_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int line_w, input int sets);
    return addr_w - idx_w(sets) - off_w(line_w);
  endfunction
endpackage

// File: rtl/dcache_way.sv
// dcache_way: one cache way with valid/dirty/tag/data arrays, combinational read,
// full-line refill or single-word store write, async clear of valid and dirty.
module dcache_way
  import dcache_pkg::*;
#(
  parameter int LINE_W = 256,
  parameter int SETS   = 16,
  parameter int TAG_W  = 23,
  localparam int IDX_W  = idx_w(SETS),
  localparam int WSEL_W = off_w(LINE_W) - 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic              valid_o,
  output logic              dirty_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [LINE_W-1:0] line_o,
  input  logic              fill_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [LINE_W-1:0] line_i,
  input  logic              store_i,
  input  logic [WSEL_W-1:0] wsel_i,
  input  logic [WORD_W-1:0] word_i
);
  logic [SETS-1:0]   valid, dirty;
  logic [TAG_W-1:0]  tags [SETS];
  logic [LINE_W-1:0] data [SETS];

  assign valid_o = valid[idx_i];
  assign dirty_o = dirty[idx_i];
  assign tag_o   = tags[idx_i];
  assign line_o  = data[idx_i];

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_i) begin
      valid[idx_i] <= 1'b1;
      dirty[idx_i] <= 1'b0;
    end else if (store_i) dirty[idx_i] <= 1'b1;

  // Tag and data storage are plain memories; validity alone gates their use.
  always_ff @(posedge clk_i) begin
    if (fill_i) begin
      tags[idx_i] <= tag_i;
      data[idx_i] <= line_i;
    end
    if (store_i) data[idx_i][wsel_i*WORD_W +: WORD_W] <= word_i;
  end
endmodule

// File: rtl/dcache_2way.sv
// dcache_2way: two-way set-associative write-back, write-allocate data cache with LRU.
// Optional hit/miss/write-back counters are built when DCACHE_PERF_CNT_EN is defined.
module dcache_2way
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [31:0]       p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o,
  output logic [31:0]       wb_cnt_o
`endif
);
  localparam int OFF_W  = off_w(LINE_W);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, LINE_W, SETS);
  localparam int WSEL_W = OFF_W - 2;

  state_t            state;
  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  idx;
  logic [WSEL_W-1:0] wsel;
  logic [1:0]        v, d, hw, fill, store;
  logic [TAG_W-1:0]  wtag [2];
  logic [LINE_W-1:0] wline [2];
  logic [LINE_W-1:0] hit_line;
  logic [SETS-1:0]   lru;
  logic              req, hit, victim, wb, unused_lsb;

  assign tag        = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign idx        = p1_addr_i[OFF_W +: IDX_W];
  assign wsel       = p1_addr_i[2 +: WSEL_W];
  assign unused_lsb = ^p1_addr_i[1:0];

  for (genvar w = 0; w < 2; w++) begin : g_way
    dcache_way #(.LINE_W(LINE_W), .SETS(SETS), .TAG_W(TAG_W)) u_way (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .idx_i   (idx),
      .valid_o (v[w]),
      .dirty_o (d[w]),
      .tag_o   (wtag[w]),
      .line_o  (wline[w]),
      .fill_i  (fill[w]),
      .tag_i   (tag),
      .line_i  (mem_data_i),
      .store_i (store[w]),
      .wsel_i  (wsel),
      .word_i  (p1_data_i)
    );
    assign hw[w]    = v[w] & (wtag[w] == tag);
    assign fill[w]  = (state == REFILL) & mem_ack_i & (victim == 1'(w));
    assign store[w] = p1_MemWrite_i & hw[w];
  end

  assign req        = p1_MemRead_i | p1_MemWrite_i;
  assign hit        = req & |hw;
  assign p1_stall_o = req & ~hit;
  assign hit_line   = hw[1] ? wline[1] : wline[0];
  assign p1_data_o  = hit ? hit_line[wsel*WORD_W +: WORD_W] : '0;
  assign wb         = v[victim] & d[victim];

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state        <= IDLE;
      lru          <= '0;
      victim       <= 1'b0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      // LRU points at the way that was not just used.
      if (hit) lru[idx] <= hw[0];
      case (state)
        IDLE: if (p1_stall_o) begin
          state  <= MISS;
          victim <= v[0] & (~v[1] | lru[idx]);
        end
        MISS: begin
          state        <= wb ? WRITEBACK : REFILL;
          mem_enable_o <= 1'b1;
          mem_write_o  <= wb;
          mem_addr_o   <= {wb ? wtag[victim] : tag, idx, {OFF_W{1'b0}}};
          mem_data_o   <= wline[victim];
        end
        WRITEBACK: if (mem_ack_i) begin
          state       <= REFILL;
          mem_write_o <= 1'b0;
          mem_addr_o  <= {tag, idx, {OFF_W{1'b0}}};
        end
        REFILL: if (mem_ack_i) begin
          state        <= DONE;
          mem_enable_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end

`ifdef DCACHE_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      wb_cnt_o   <= '0;
    end else begin
      if (hit && (state == IDLE || state == DONE) && ~&hit_cnt_o) hit_cnt_o <= hit_cnt_o + 1'b1;
      if (state == IDLE && p1_stall_o && ~&miss_cnt_o) miss_cnt_o <= miss_cnt_o + 1'b1;
      if (state == MISS && wb && ~&wb_cnt_o) wb_cnt_o <= wb_cnt_o + 1'b1;
    end
`endif
endmodule

// File: tb/tb_dcache_2way.sv
// tb_dcache_2way: directed scoreboard bench; loads and memory transactions are queued
// as expectations and popped by a monitor when the cache presents them.
module tb_dcache_2way;
  localparam int LAT = 4;

  typedef struct packed {
    logic [31:0]  addr;
    logic         wr;
    logic [255:0] data;
  } mem_exp_t;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic [31:0]  p1_addr = '0, p1_wdata = '0, p1_rdata;
  logic         p1_rd = 1'b0, p1_wr = 1'b0, stall;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata, mem_rdata = '0, wb_line;
  logic         mem_en, mem_we, mem_ack = 1'b0, spur = 1'b0;
  int           checks = 0, errors = 0;
  logic [31:0]  ld_q [$];
  mem_exp_t     mem_q [$];
  logic [255:0] memory [logic [31:0]];
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]  hit_cnt, miss_cnt, wb_cnt;
`endif

  always #5 clk = ~clk;

  dcache_2way dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .p1_addr_i     (p1_addr),
    .p1_data_i     (p1_wdata),
    .p1_MemRead_i  (p1_rd),
    .p1_MemWrite_i (p1_wr),
    .p1_data_o     (p1_rdata),
    .p1_stall_o    (stall),
    .mem_addr_o    (mem_addr),
    .mem_data_o    (mem_wdata),
    .mem_enable_o  (mem_en),
    .mem_write_o   (mem_we),
    .mem_data_i    (spur ? {256{1'b1}} : mem_rdata),
    .mem_ack_i     (mem_ack | spur)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .hit_cnt_o     (hit_cnt),
    .miss_cnt_o    (miss_cnt),
    .wb_cnt_o      (wb_cnt)
`endif
  );

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = 32'hA000_0000 | (a + 32'(4 * k));
    return l;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_mem(input logic [31:0] a, input logic w, input logic [255:0] dat);
    mem_exp_t e;
    e.addr = a;
    e.wr   = w;
    e.data = dat;
    mem_q.push_back(e);
  endtask

  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] dat,
                        input int exp_stall, input logic [31:0] exp_rd);
    int n = 0;
    @(posedge clk); #1;
    p1_addr = a; p1_wdata = dat; p1_rd = !w; p1_wr = w;
    if (!w) ld_q.push_back(exp_rd);
    forever begin
      @(negedge clk);
      if (!stall) break;
      n++;
      if (n > 200) break;
    end
    chk($sformatf("stall_cycles@%0h", a), 256'(n), 256'(exp_stall));
    @(posedge clk); #1;
    p1_rd = 1'b0; p1_wr = 1'b0;
  endtask

  // Memory responder: ack arrives LAT cycles after the request first appears.
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        mem_ack = 1'b0; cnt = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0; cnt = mem_en ? 1 : 0;
      end else if (mem_en) begin
        cnt++;
        if (cnt == LAT + 1) begin
          mem_ack = 1'b1;
          if (mem_we) memory[mem_addr] = mem_wdata;
          else mem_rdata = memory.exists(mem_addr) ? memory[mem_addr] : line_of(mem_addr);
        end
      end else cnt = 0;
    end
  end

  // Monitor: pops expectations when a load completes or a memory transfer is acked.
  always @(negedge clk) begin
    if (rst_n && p1_rd && !stall) begin
      if (ld_q.size() == 0) begin
        errors++;
        $display("FAIL load_unexpected: got %0h expected no completion", p1_rdata);
      end else chk("load_data", 256'(p1_rdata), 256'(ld_q.pop_front()));
    end
    if (rst_n && mem_en && mem_ack) begin
      if (mem_q.size() == 0) begin
        errors++;
        $display("FAIL mem_unexpected: got addr %0h expected no transfer", mem_addr);
      end else begin
        mem_exp_t e;
        e = mem_q.pop_front();
        chk("mem_addr", 256'(mem_addr), 256'(e.addr));
        chk("mem_write", 256'(mem_we), 256'(e.wr));
        if (e.wr) chk("mem_wb_data", mem_wdata, e.data);
      end
    end
    if (rst_n)
      assert (!(dut.hw[0] & dut.hw[1])) else begin
        errors++;
        $display("FAIL double_match: got hit ways %b expected at most one", dut.hw);
      end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_mem_enable", 256'(mem_en), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mem_write", 256'(mem_we), 256'(0));
    chk("rst_mem_addr", 256'(mem_addr), 256'(0));
    chk("rst_mem_data", mem_wdata, 256'(0));
    chk("rst_stall", 256'(stall), 256'(0));
    chk("idle_rdata", 256'(p1_rdata), 256'(0));

    exp_mem(32'h40, 1'b0, '0);
    access(1'b0, 32'h40, 0, 7, 32'hA000_0040);
    access(1'b0, 32'h40, 0, 0, 32'hA000_0040);
`ifdef DCACHE_PERF_CNT_EN
    chk("hit_cnt_a", 256'(hit_cnt), 256'(2));
    chk("miss_cnt_a", 256'(miss_cnt), 256'(1));
`endif
    access(1'b1, 32'h44, 32'hDEAD_BEEF, 0, 0);
    access(1'b0, 32'h44, 0, 0, 32'hDEAD_BEEF);
    access(1'b0, 32'h40, 0, 0, 32'hA000_0040);
    access(1'b0, 32'h48, 0, 0, 32'hA000_0048);

    exp_mem(32'h000, 1'b0, '0);
    access(1'b0, 32'h000, 0, 7, 32'hA000_0000);
    exp_mem(32'h200, 1'b0, '0);
    access(1'b0, 32'h200, 0, 7, 32'hA000_0200);
    access(1'b0, 32'h000, 0, 0, 32'hA000_0000);
    exp_mem(32'h400, 1'b0, '0);
    access(1'b0, 32'h400, 0, 7, 32'hA000_0400);
    access(1'b0, 32'h000, 0, 0, 32'hA000_0000);
    exp_mem(32'h200, 1'b0, '0);
    access(1'b0, 32'h200, 0, 7, 32'hA000_0200);

    access(1'b1, 32'h204, 32'h1234_5678, 0, 0);
    access(1'b0, 32'h000, 0, 0, 32'hA000_0000);
    wb_line = line_of(32'h200);
    wb_line[63:32] = 32'h1234_5678;
    exp_mem(32'h200, 1'b1, wb_line);
    exp_mem(32'h400, 1'b0, '0);
    access(1'b0, 32'h400, 0, 12, 32'hA000_0400);
`ifdef DCACHE_PERF_CNT_EN
    chk("wb_cnt", 256'(wb_cnt), 256'(1));
`endif
    exp_mem(32'h200, 1'b0, '0);
    access(1'b0, 32'h204, 0, 7, 32'h1234_5678);

    // Abort a refill with reset.
    @(posedge clk); #1;
    p1_addr = 32'h600; p1_rd = 1'b1;
    begin
      int n = 0;
      while (!mem_en && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("abort_enable_seen", 256'(mem_en), 256'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_async_enable", 256'(mem_en), 256'(0));
    chk("rst_async_stall", 256'(stall), 256'(1));
    p1_rd = 1'b0;
    mem_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    exp_mem(32'h600, 1'b0, '0);
    access(1'b0, 32'h600, 0, 7, 32'hA000_0600);
    exp_mem(32'h40, 1'b0, '0);
    access(1'b0, 32'h40, 0, 7, 32'hA000_0040);

    // Spurious ack while idle must be ignored.
    @(posedge clk); #1;
    p1_addr = 32'h40; spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    @(negedge clk);
    chk("spur_enable", 256'(mem_en), 256'(0));
    access(1'b0, 32'h40, 0, 0, 32'hA000_0040);
    access(1'b0, 32'h600, 0, 0, 32'hA000_0600);
`ifdef DCACHE_PERF_CNT_EN
    chk("hit_cnt_end", 256'(hit_cnt), 256'(4));
    chk("miss_cnt_end", 256'(miss_cnt), 256'(2));
    chk("wb_cnt_end", 256'(wb_cnt), 256'(0));
`endif
    repeat (2) @(negedge clk);
    chk("ld_q_drained", 256'(ld_q.size()), 256'(0));
    chk("mem_q_drained", 256'(mem_q.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
